mem_access_unit: RTL

//  MEM-stage data-memory access unit; the consumer of the EX/MEM pipeline register outputs.

---
 rtl/mem_access_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: decodes READ_WRITE, runs one REQ/ACK word access, steers byte lanes, extends loads.
// Optional MISALIGN_CHECK_EN: misaligned half/word accesses are flagged on MISALIGNED instead of reaching memory.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AW     = 30
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [3:0]            READ_WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [31:0]           WRITE_DATA,
    output logic [31:0]           READ_DATA,
    output logic                  BUSYWAIT,
    output logic                  MISALIGNED,
    output logic                  MEM_REQ,
    output logic                  MEM_WE,
    output logic [MEM_AW-1:0]     MEM_ADDR,
    output logic [31:0]           MEM_WDATA,
    output logic [3:0]            MEM_BE,
    input  logic [31:0]           MEM_RDATA,
    input  logic                  MEM_ACK
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] read_data_q, read_data_d;
    logic        misaligned_q, misaligned_d;

    logic        is_load, is_store, is_valid, ld_unsigned, bad_align;
    logic [1:0]  size;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // size: 00 byte, 01 half, 10 word; store codes sit one above their size
    always_comb begin
        is_load     = READ_WRITE[3] && (READ_WRITE[2:0] == 3'b000 || READ_WRITE[2:0] == 3'b001 ||
                                        READ_WRITE[2:0] == 3'b010 || READ_WRITE[2:0] == 3'b100 ||
                                        READ_WRITE[2:0] == 3'b101);
        is_store    = (READ_WRITE[3:2] == 2'b00) && (READ_WRITE[1:0] != 2'b00);
        is_valid    = is_load || is_store;
        ld_unsigned = READ_WRITE[2];
        size        = READ_WRITE[1:0];
        if (!READ_WRITE[3]) begin
            size = READ_WRITE[1:0] - 2'd1;
        end
`ifdef MISALIGN_CHECK_EN
        bad_align = (size == 2'b01 && ADDRESS[0]) || (size == 2'b10 && ADDRESS[1:0] != 2'b00);
`else
        bad_align = 1'b0;
`endif
    end

    always_comb begin
        MEM_BE    = 4'b1111;
        MEM_WDATA = WRITE_DATA;
        if (is_store) begin
            case (size)
                2'b00: begin
                    MEM_BE    = 4'b0001 << ADDRESS[1:0];
                    MEM_WDATA = {4{WRITE_DATA[7:0]}};
                end
                2'b01: begin
                    MEM_BE    = ADDRESS[1] ? 4'b1100 : 4'b0011;
                    MEM_WDATA = {2{WRITE_DATA[15:0]}};
                end
                default: begin
                    MEM_BE    = 4'b1111;
                    MEM_WDATA = WRITE_DATA;
                end
            endcase
        end
    end

    always_comb begin
        case (ADDRESS[1:0])
            2'b00:   ld_byte = MEM_RDATA[7:0];
            2'b01:   ld_byte = MEM_RDATA[15:8];
            2'b10:   ld_byte = MEM_RDATA[23:16];
            default: ld_byte = MEM_RDATA[31:24];
        endcase
        ld_half = ADDRESS[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
        case (size)
            2'b00:   ld_ext = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = MEM_RDATA;
        endcase
    end

    // DONE always returns to IDLE so a held READ_WRITE is not re-issued in the same slot
    always_comb begin
        state_d      = state_q;
        read_data_d  = read_data_q;
        misaligned_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_valid) begin
                    if (bad_align) begin
                        state_d      = S_DONE;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (MEM_ACK) begin
                    state_d = S_DONE;
                    if (is_load) begin
                        read_data_d = ld_ext;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            read_data_q  <= 32'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_data_q  <= read_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign READ_DATA  = read_data_q;
    assign MISALIGNED = misaligned_q;
    assign MEM_REQ    = (state_q == S_REQ);
    assign MEM_WE     = is_store;
    assign MEM_ADDR   = ADDRESS[ADDR_WIDTH-1:2];
    assign BUSYWAIT   = !RESET && ((state_q == S_IDLE && is_valid) || state_q == S_REQ);

endmodule
